ifetch_unit: RTL



---
 rtl/ifetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one 32-bit read at a time and hands
// (pc, instr) to decode via a valid/ready slot. Optional macro: IFETCH_MISALIGN_CHK_EN.
module ifetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            ibus_req_valid,
  output logic [XLEN-1:0] ibus_req_addr,
  input  logic            ibus_resp_ok,
  input  logic [31:0]     ibus_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            f_valid,
  output logic [XLEN-1:0] f_pc,
  output logic [31:0]     f_instr,
`ifdef IFETCH_MISALIGN_CHK_EN
  output logic            f_misalign,
`endif
  input  logic            d_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic            r_f_valid;
  logic [XLEN-1:0] r_f_pc;
  logic [31:0]     r_f_instr;

  logic            w_slot_free;
  logic            w_issue;
  logic            w_complete;
  logic [XLEN-1:0] w_cur_addr;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_next;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic r_f_misalign;
  logic r_mis_pend;   // misaligned target latched, NOP not yet delivered
  logic r_mis_stall;  // NOP delivered, wait for the next redirect
  logic w_mis_fill;

  assign w_redirect_pc = redirect_pc;
  assign w_mis_fill    = (r_state == IDLE) && w_slot_free && !redirect_valid && r_mis_pend;
  assign w_issue       = reset_n && (r_state == IDLE) && w_slot_free && !redirect_valid &&
                         !r_mis_pend && !r_mis_stall;
  assign f_misalign    = r_f_misalign;
`else
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);
  assign w_issue       = reset_n && (r_state == IDLE) && w_slot_free && !redirect_valid;
`endif

  assign w_slot_free = !r_f_valid || d_ready;
  // An IDLE-cycle request completing in the same cycle is treated like a BUSY completion.
  assign w_complete  = ibus_resp_ok && !redirect_valid && (w_issue || (r_state == BUSY));
  assign w_cur_addr  = (r_state == IDLE) ? r_pc : r_req_addr;
  assign w_pc_next   = r_pc + XLEN'(4);

  assign ibus_req_valid = w_issue || (reset_n && (r_state != IDLE));
  assign ibus_req_addr  = ibus_req_valid ? w_cur_addr : '0;

  assign f_valid = r_f_valid;
  assign f_pc    = r_f_pc;
  assign f_instr = r_f_instr;

  // NOTE: all state uses non-blocking assignments; later assignments in this block
  // deliberately override earlier ones (a new fill beats a handshake clear).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_f_valid  <= 1'b0;
      r_f_pc     <= '0;
      r_f_instr  <= '0;
`ifdef IFETCH_MISALIGN_CHK_EN
      r_f_misalign <= 1'b0;
      r_mis_pend   <= 1'b0;
      r_mis_stall  <= 1'b0;
`endif
    end else begin
      if (r_f_valid && d_ready) begin
        r_f_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        r_f_misalign <= 1'b0;
`endif
      end

      if (redirect_valid) begin
        r_pc      <= w_redirect_pc;
        r_f_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        r_f_misalign <= 1'b0;
        r_mis_pend   <= |redirect_pc[1:0];
        r_mis_stall  <= 1'b0;
`endif
        if (r_state != IDLE) r_state <= ibus_resp_ok ? IDLE : DISCARD;
      end else begin
        if (w_complete) begin
          r_f_valid <= 1'b1;
          r_f_pc    <= w_cur_addr;
          r_f_instr <= ibus_resp_data;
          r_pc      <= w_pc_next;
        end

        unique case (r_state)
          IDLE: begin
            if (w_issue && !ibus_resp_ok) begin
              r_state    <= BUSY;
              r_req_addr <= r_pc;
            end
          end
          BUSY, DISCARD: begin
            if (ibus_resp_ok) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase

`ifdef IFETCH_MISALIGN_CHK_EN
        if (w_mis_fill) begin
          r_f_valid    <= 1'b1;
          r_f_misalign <= 1'b1;
          r_f_pc       <= r_pc;
          r_f_instr    <= NOP_INSTR;
          r_mis_pend   <= 1'b0;
          r_mis_stall  <= 1'b1;
        end
`endif
      end
    end
  end

endmodule
